// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported RAM between the fetch and data paths
//   CLK, RST                       clock, synchronous active-high reset
//   iREN, iaddr                    fetch request (held until ihit)
//   dREN, dWEN, daddr, dstore      data request (held until dhit; both high = write)
//   ihit, iload / dhit, dload      completion pulses with the returned word
//   ramREN, ramWEN, ramaddr,
//   ramstore, ramload, ram_done    RAM controller side
//   err                            pulse when an access is aborted by timeout
module memory_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 64,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_done,
    output logic              err
);
    localparam int CW = $clog2(TIMEOUT);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;
    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] store;
    logic              we;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     dstreak;
    logic              grant_d, busy, timeout;
    always_comb begin
        // data wins unless the fetch has been passed over MAX_DSTREAK times in a row
        grant_d  = (dREN | dWEN) & ~(iREN & dstreak == STREAK_MAX);
        busy     = state != IDLE;
        timeout  = busy & ~ram_done & cnt == CNT_MAX;
        // a completion arriving together with reset is dropped
        ihit     = ~RST & state == IACC & ram_done;
        dhit     = ~RST & state == DACC & ram_done;
        err      = ~RST & timeout;
        iload    = ihit ? ramload : '0;
        dload    = dhit ? ramload : '0;
        ramREN   = state == IACC | (state == DACC & ~we);
        ramWEN   = state == DACC & we;
        ramaddr  = busy ? addr : '0;
        ramstore = busy ? store : '0;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            addr    <= '0;
            store   <= '0;
            we      <= 1'b0;
            cnt     <= '0;
            dstreak <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (grant_d) begin
                state   <= DACC;
                addr    <= daddr;
                store   <= dstore;
                we      <= dWEN;
                // grant_d with iREN implies dstreak < STREAK_MAX, so no overflow
                dstreak <= iREN ? dstreak + 1'b1 : '0;
            end else if (iREN) begin
                state   <= IACC;
                addr    <= iaddr;
                store   <= '0;
                we      <= 1'b0;
                dstreak <= '0;
            end
        end else if (ram_done | timeout) begin
            state <= IDLE;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and randomized checks of memory_arbiter against a transaction model
module tb_memory_arbiter;
    localparam int TO = 8;
    localparam int MD = 4;
    logic        clk = 1'b0;
    logic        RST, iREN, dREN, dWEN, ram_done;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        ihit, dhit, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    int          n_cmp = 0;
    int          n_bad = 0;
    // transaction model: whether an access is outstanding, who owns it, its age, the data streak
    bit          mb, md, mwe;
    logic [31:0] maddr, mdata;
    int          mage, mstreak;
    logic        e_ihit, e_dhit, e_err, e_ren, e_wen;
    logic [31:0] e_iload, e_dload, e_addr, e_store;

    memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .MAX_DSTREAK(MD)) dut (
        .CLK(clk), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_done(ram_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        e_ren   = mb && (!md || !mwe);
        e_wen   = mb && md && mwe;
        e_addr  = mb ? maddr : 32'h0;
        e_store = mb ? mdata : 32'h0;
        e_ihit  = !RST && mb && !md && ram_done;
        e_dhit  = !RST && mb && md && ram_done;
        e_err   = !RST && mb && !ram_done && mage == TO - 1;
        e_iload = e_ihit ? ramload : 32'h0;
        e_dload = e_dhit ? ramload : 32'h0;
        chk("ramREN", ramREN, e_ren);
        chk("ramWEN", ramWEN, e_wen);
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
        chk("ihit", ihit, e_ihit);
        chk("dhit", dhit, e_dhit);
        chk("err", err, e_err);
        chk("iload", iload, e_iload);
        chk("dload", dload, e_dload);
    endtask

    function automatic void model_step();
        if (RST) begin
            mb = 0;
            mage = 0;
            mstreak = 0;
        end else if (!mb) begin
            if ((dREN || dWEN) && !(iREN && mstreak >= MD)) begin
                mb = 1; md = 1; mwe = dWEN; maddr = daddr; mdata = dstore; mage = 0;
                mstreak = iREN ? ((mstreak + 1 > MD) ? MD : mstreak + 1) : 0;
            end else if (iREN) begin
                mb = 1; md = 0; mwe = 0; maddr = iaddr; mdata = 0; mage = 0;
                mstreak = 0;
            end
        end else if (ram_done || mage == TO - 1) begin
            mb = 0;
        end else begin
            mage++;
        end
    endfunction

    task automatic adv();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    task automatic clr();
        iREN = 0; dREN = 0; dWEN = 0; ram_done = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    endtask

    initial begin
        logic [31:0] seen[$];
        logic [31:0] order[6];
        int hits;
        order = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h100, 32'h200};
        clr();
        RST = 1;
        @(posedge clk);
        #1;
        cyc();
        RST = 0;
        // reset state
        sample();
        chk("rst_ren", ramREN, 0);
        chk("rst_wen", ramWEN, 0);
        chk("rst_addr", ramaddr, 0);
        chk("rst_hits", {ihit, dhit, err}, 0);
        adv();
        // single fetch, RAM answers in the 4th access cycle
        iREN = 1; iaddr = 32'h40;
        sample();
        chk("fetch_idle_ren", ramREN, 0);
        adv();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                ram_done = 1;
                ramload = 32'hDEADBEEF;
            end
            sample();
            chk("fetch_ren", ramREN, 1);
            chk("fetch_addr", ramaddr, 32'h40);
            chk("fetch_ihit", ihit, k == 4);
            chk("fetch_iload", iload, (k == 4) ? 32'hDEADBEEF : 32'h0);
            adv();
        end
        clr();
        sample();
        chk("fetch_after_ren", ramREN, 0);
        adv();
        // collision: write goes first, fetch after one idle cycle
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
        cyc();
        ram_done = 1;
        sample();
        chk("coll_wen", ramWEN, 1);
        chk("coll_ren", ramREN, 0);
        chk("coll_store", ramstore, 32'h1234);
        chk("coll_addr", ramaddr, 32'h80);
        chk("coll_dhit", dhit, 1);
        adv();
        dWEN = 0; ram_done = 0;
        sample();
        chk("coll_gap", {ramREN, ramWEN}, 0);
        adv();
        ram_done = 1; ramload = 32'hCAFE0001;
        sample();
        chk("coll_fetch_ren", ramREN, 1);
        chk("coll_fetch_addr", ramaddr, 32'h44);
        chk("coll_fetch_ihit", ihit, 1);
        adv();
        clr();
        cyc();
        // starvation guard with a zero-wait RAM
        dREN = 1; daddr = 32'h200; iREN = 1; iaddr = 32'h100; ram_done = 1;
        hits = 0;
        for (int k = 0; k < 12; k++) begin
            sample();
            if (ramREN || ramWEN) seen.push_back(ramaddr);
            hits += int'(ihit) + int'(dhit);
            adv();
        end
        chk("zw_hits", hits, 6);
        chk("starve_cnt", seen.size(), 6);
        for (int k = 0; k < 6 && k < seen.size(); k++) chk("starve_order", seen[k], order[k]);
        clr();
        cyc();
        // timeout: RAM never answers
        iREN = 1; iaddr = 32'h300;
        sample();
        chk("tmo_idle_ren", ramREN, 0);
        adv();
        for (int k = 1; k <= 8; k++) begin
            sample();
            chk("tmo_ren", ramREN, 1);
            chk("tmo_err", err, k == 8);
            chk("tmo_ihit", ihit, 0);
            adv();
        end
        sample();
        chk("tmo_gap_ren", ramREN, 0);
        chk("tmo_gap_err", err, 0);
        adv();
        ram_done = 1; ramload = 32'h55AA;
        sample();
        chk("tmo_regrant_ren", ramREN, 1);
        chk("tmo_regrant_addr", ramaddr, 32'h300);
        chk("tmo_regrant_ihit", ihit, 1);
        adv();
        clr();
        cyc();
        // reset in the middle of a data read, completion in the same cycle
        dREN = 1; daddr = 32'h10;
        cyc();
        RST = 1; ram_done = 1; ramload = 32'h77;
        sample();
        chk("rstacc_dhit", dhit, 0);
        chk("rstacc_dload", dload, 0);
        adv();
        RST = 0;
        clr();
        sample();
        chk("rstacc_after", {ramREN, ramWEN, dhit, ihit, err}, 0);
        chk("rstacc_addr", ramaddr, 0);
        adv();
        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            RST = ($urandom_range(0, 199) == 0);
            if (iREN && e_ihit && $urandom_range(0, 1) == 1) iREN = 0;
            else if (!iREN && $urandom_range(0, 3) == 0) begin
                iREN = 1;
                iaddr = $urandom;
            end else if ($urandom_range(0, 31) == 0) iREN = 0;
            if ((dREN || dWEN) && e_dhit && $urandom_range(0, 1) == 1) begin
                dREN = 0;
                dWEN = 0;
            end else if (!(dREN || dWEN) && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin dREN = 1; dWEN = 0; end
                    1: begin dREN = 0; dWEN = 1; end
                    default: begin dREN = 1; dWEN = 1; end
                endcase
                daddr = $urandom;
                dstore = $urandom;
            end else if ($urandom_range(0, 31) == 0) begin
                dREN = 0;
                dWEN = 0;
            end
            ram_done = (c % 400 < 40) ? 1'b0 : ($urandom_range(0, 2) == 0);
            ramload = $urandom;
            cyc();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
